branch_predict_controller: RTL

- Dynamic branch predictor and fetch-redirect controller for the 5-stage pipelined RISC-V core.
- Steers the IF-stage next-PC mux and flushes wrong-path instructions.
- At fetch: looks up a direct-mapped table of 2-bit saturating counters plus a tagged branch target buffer (BTB), and supplies a predicted next PC.
- At branch resolution in the MEM stage: updates the tables, detects mispredictions, and drives the redirect PC and pipeline-register flushes.

---
 rtl/branch_predict_controller_pkg.sv | 47 ++++
 rtl/branch_predict_controller_if.sv | 36 +++
 rtl/branch_predict_controller_btb.sv | 48 ++++
 rtl/branch_predict_controller.sv | 122 ++++++++++++
 4 files changed

// File: rtl/branch_predict_controller_pkg.sv
// Shared definitions for the branch predictor: counter states, default table
// geometry and the PC-to-index / PC-to-tag mapping used by fetch and resolve.
package bp_pkg;

  localparam int DEF_INDEX_BITS = 4;
  localparam int DEF_TAG_BITS   = 8;

  // 2-bit saturating counter; the upper bit is the taken prediction
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } pht_state_e;

  // Table index: PC[index_bits+1:2], returned zero-extended
  function automatic logic [63:0] bp_index(input logic [63:0] pc,
                                           input int unsigned index_bits);
    return (pc >> 2) & ((64'd1 << index_bits) - 64'd1);
  endfunction

  // BTB tag: the tag_bits directly above the index field, zero-extended
  function automatic logic [63:0] bp_tag(input logic [63:0] pc,
                                         input int unsigned index_bits,
                                         input int unsigned tag_bits);
    return (pc >> (index_bits + 2)) & ((64'd1 << tag_bits) - 64'd1);
  endfunction

  // Saturating step of a counter toward taken or not-taken
  function automatic pht_state_e pht_next(input pht_state_e s, input logic taken);
    pht_state_e n;
    case (s)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? WT  : SNT;
      WT:      n = taken ? ST  : WNT;
      ST:      n = taken ? ST  : WT;
      default: n = WNT;
    endcase
    return n;
  endfunction

  // Predict bit of a counter
  function automatic logic pht_predict(input pht_state_e s);
    return (s == WT) || (s == ST);
  endfunction

endpackage

// File: rtl/branch_predict_controller_if.sv
// Fetch-side and resolve-side signals between the pipeline (master) and the
// branch predictor / redirect controller (slave).
interface branch_predict_controller_if #(
  parameter int STAT_BITS = 32
);
  logic [63:0]          fetch_pc;
  logic                 predict_taken;
  logic [63:0]          predict_pc;
  logic                 resolve_valid;
  logic [63:0]          resolve_pc;
  logic                 resolve_taken;
  logic [63:0]          resolve_target;
  logic                 resolve_pred_taken;
  logic [63:0]          resolve_pred_pc;
  logic                 mispredict;
  logic [63:0]          redirect_pc;
  logic                 flush_if_id;
  logic                 flush_id_ex;
  logic                 flush_ex_mem;
  logic [STAT_BITS-1:0] branch_count;
  logic [STAT_BITS-1:0] mispredict_count;

  modport master (
    output fetch_pc, resolve_valid, resolve_pc, resolve_taken, resolve_target,
           resolve_pred_taken, resolve_pred_pc,
    input  predict_taken, predict_pc, mispredict, redirect_pc,
           flush_if_id, flush_id_ex, flush_ex_mem, branch_count, mispredict_count
  );

  modport slave (
    input  fetch_pc, resolve_valid, resolve_pc, resolve_taken, resolve_target,
           resolve_pred_taken, resolve_pred_pc,
    output predict_taken, predict_pc, mispredict, redirect_pc,
           flush_if_id, flush_id_ex, flush_ex_mem, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predict_controller_btb.sv
// Direct-mapped branch target buffer: one combinational read port for fetch,
// one clocked write port for resolution. Only the valid bits are reset; tag
// and target contents are meaningless while their valid bit is clear.
module branch_target_buffer
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int TAG_BITS   = DEF_TAG_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [63:0]           rd_target,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [63:0]           wr_target
);
  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [ENTRIES-1:0]  valid_r;
  logic [TAG_BITS-1:0] tag_r    [ENTRIES];
  logic [63:0]         target_r [ENTRIES];

  // Valid bits: cleared asynchronously, set by a taken resolution
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= {ENTRIES{1'b0}};
    end else if (wr_en) begin
      valid_r[wr_index] <= 1'b1;
    end
  end

  // Tag and target storage, written together with the valid bit
  always_ff @(posedge clk) begin
    if (wr_en && reset) begin
      tag_r[wr_index]    <= wr_tag;
      target_r[wr_index] <= wr_target;
    end
  end

  assign rd_valid  = valid_r[rd_index];
  assign rd_tag    = tag_r[rd_index];
  assign rd_target = target_r[rd_index];

endmodule

// File: rtl/branch_predict_controller.sv
// Dynamic branch predictor and fetch-redirect controller. Fetch lookup is
// combinational against pre-edge table state; resolution detects
// mispredictions combinationally and trains the tables on the clock edge.
module branch_predict_controller
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int TAG_BITS   = DEF_TAG_BITS,
  parameter int STAT_BITS  = 32
) (
  input logic clk,
  input logic reset,
  branch_predict_controller_if.slave bp
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [STAT_BITS-1:0] STAT_MAX = {STAT_BITS{1'b1}};
  localparam logic [STAT_BITS-1:0] STAT_ONE = {{(STAT_BITS-1){1'b0}}, 1'b1};

  pht_state_e            pht_r [ENTRIES];
  logic [STAT_BITS-1:0]  branch_count_r;
  logic [STAT_BITS-1:0]  mispredict_count_r;

  logic [INDEX_BITS-1:0] fetch_idx_s;
  logic [TAG_BITS-1:0]   fetch_tag_s;
  logic [INDEX_BITS-1:0] res_idx_s;
  logic [TAG_BITS-1:0]   res_tag_s;
  logic                  btb_valid_s;
  logic [TAG_BITS-1:0]   btb_tag_s;
  logic [63:0]           btb_target_s;
  logic                  predict_taken_s;
  logic [63:0]           predict_pc_s;
  logic                  mispredict_s;
  logic [63:0]           redirect_pc_s;

  assign fetch_idx_s = INDEX_BITS'(bp_index(bp.fetch_pc, INDEX_BITS));
  assign fetch_tag_s = TAG_BITS'(bp_tag(bp.fetch_pc, INDEX_BITS, TAG_BITS));
  assign res_idx_s   = INDEX_BITS'(bp_index(bp.resolve_pc, INDEX_BITS));
  assign res_tag_s   = TAG_BITS'(bp_tag(bp.resolve_pc, INDEX_BITS, TAG_BITS));

  branch_target_buffer #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_btb (
    .clk       (clk),
    .reset     (reset),
    .rd_index  (fetch_idx_s),
    .rd_valid  (btb_valid_s),
    .rd_tag    (btb_tag_s),
    .rd_target (btb_target_s),
    .wr_en     (bp.resolve_valid & bp.resolve_taken),
    .wr_index  (res_idx_s),
    .wr_tag    (res_tag_s),
    .wr_target (bp.resolve_target)
  );

  // Fetch lookup: taken only on a BTB hit whose counter predicts taken
  always_comb begin
    predict_taken_s = 1'b0;
    predict_pc_s    = bp.fetch_pc + 64'd4;
    if (btb_valid_s && (btb_tag_s == fetch_tag_s) && pht_predict(pht_r[fetch_idx_s])) begin
      predict_taken_s = 1'b1;
      predict_pc_s    = btb_target_s;
    end else begin
      predict_taken_s = 1'b0;
      predict_pc_s    = bp.fetch_pc + 64'd4;
    end
  end

  // Resolution check: wrong direction, or right direction with wrong target
  always_comb begin
    mispredict_s  = 1'b0;
    redirect_pc_s = bp.resolve_taken ? bp.resolve_target : (bp.resolve_pc + 64'd4);
    if (reset && bp.resolve_valid) begin
      if (bp.resolve_taken != bp.resolve_pred_taken) begin
        mispredict_s = 1'b1;
      end else if (bp.resolve_taken && (bp.resolve_target != bp.resolve_pred_pc)) begin
        mispredict_s = 1'b1;
      end else begin
        mispredict_s = 1'b0;
      end
    end else begin
      mispredict_s = 1'b0;
    end
  end

  // Pattern history: train the resolving branch's counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht_r[i] <= WNT;
      end
    end else if (bp.resolve_valid) begin
      pht_r[res_idx_s] <= pht_next(pht_r[res_idx_s], bp.resolve_taken);
    end
  end

  // Statistics: saturating counts of resolved and mispredicted branches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_count_r     <= {STAT_BITS{1'b0}};
      mispredict_count_r <= {STAT_BITS{1'b0}};
    end else if (bp.resolve_valid) begin
      if (branch_count_r != STAT_MAX) begin
        branch_count_r <= branch_count_r + STAT_ONE;
      end
      if (mispredict_s && (mispredict_count_r != STAT_MAX)) begin
        mispredict_count_r <= mispredict_count_r + STAT_ONE;
      end
    end
  end

  assign bp.predict_taken    = predict_taken_s;
  assign bp.predict_pc       = predict_pc_s;
  assign bp.mispredict       = mispredict_s;
  assign bp.redirect_pc      = redirect_pc_s;
  assign bp.flush_if_id      = mispredict_s;
  assign bp.flush_id_ex      = mispredict_s;
  assign bp.flush_ex_mem     = mispredict_s;
  assign bp.branch_count     = branch_count_r;
  assign bp.mispredict_count = mispredict_count_r;

endmodule
